// File: rtl/fetch_top.sv
// Fetch stage: owns the PC, the instruction-memory handshake and the IF/ID registers.
// DROP lets an abandoned request complete; HOLD parks data that decode cannot take yet.
module fetch_top #(
  parameter int ADDR_SIZE = 32,
  parameter int INSTR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = 32'h0000_1000,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_write,
  input  logic                  if_id_write,
  input  logic                  is_jump,
  input  logic [ADDR_SIZE-1:0]  jump_addr,
  input  logic                  branch_taken,
  input  logic [ADDR_SIZE-1:0]  branch_addr,
  output logic                  imem_req,
  output logic [ADDR_SIZE-1:0]  imem_addr,
  input  logic                  imem_ready,
  input  logic [INSTR_SIZE-1:0] imem_rdata,
  output logic [ADDR_SIZE-1:0]  out_pc,
  output logic [INSTR_SIZE-1:0] instruction
);

  typedef enum logic [1:0] {FETCH, DROP, HOLD} state_t;

  localparam logic [ADDR_SIZE-1:0] PC_STEP =
    {{(ADDR_SIZE-3){1'b0}}, 3'd4};

  state_t state, state_n;
  logic [ADDR_SIZE-1:0] pc, pc_n;
  logic [ADDR_SIZE-1:0] redir_pc, redir_n;
  logic [ADDR_SIZE-1:0] out_pc_n;
  logic [INSTR_SIZE-1:0] hold_instr, hold_n;
  logic [INSTR_SIZE-1:0] instr_n;
  logic accept, redirect;
  logic [ADDR_SIZE-1:0] target;

  assign accept = pc_write & if_id_write;
  assign redirect = branch_taken | (is_jump & if_id_write);
  assign target = branch_taken ? branch_addr : jump_addr;

  assign imem_req = reset & (state != HOLD);
  assign imem_addr = pc;

  always_comb begin
    state_n = state;
    pc_n = pc;
    redir_n = redir_pc;
    hold_n = hold_instr;
    out_pc_n = out_pc;
    instr_n = instruction;
    unique case (state)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_n = target;
            out_pc_n = pc;
            instr_n = NOP_INSTR;
          end else if (accept) begin
            pc_n = pc + PC_STEP;
            out_pc_n = pc;
            instr_n = imem_rdata;
          end else begin
            hold_n = imem_rdata;
            state_n = HOLD;
          end
        end else if (redirect) begin
          redir_n = target;
          out_pc_n = pc;
          instr_n = NOP_INSTR;
          state_n = DROP;
        end else if (if_id_write) begin
          out_pc_n = pc;
          instr_n = NOP_INSTR;
        end
      end
      DROP: begin
        if (redirect) redir_n = target;
        if (redirect || if_id_write) begin
          out_pc_n = pc;
          instr_n = NOP_INSTR;
        end
        if (imem_ready) begin
          pc_n = redirect ? target : redir_pc;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n = target;
          out_pc_n = pc;
          instr_n = NOP_INSTR;
          state_n = FETCH;
        end else if (accept) begin
          pc_n = pc + PC_STEP;
          out_pc_n = pc;
          instr_n = hold_instr;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      redir_pc <= '0;
      hold_instr <= '0;
      out_pc <= '0;
      instruction <= NOP_INSTR;
    end else begin
      state <= state_n;
      pc <= pc_n;
      redir_pc <= redir_n;
      hold_instr <= hold_n;
      out_pc <= out_pc_n;
      instruction <= instr_n;
    end
  end

endmodule

// File: tb/tb_fetch_top.sv
// Directed bench for fetch_top: a transaction-level model compared every cycle,
// plus literal expectations taken from the hand-worked scenario.
module tb_fetch_top;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        if_id_write;
  logic        is_jump;
  logic [31:0] jump_addr;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] out_pc;
  logic [31:0] instruction;

  int checks = 0;
  int errors = 0;

  fetch_top dut (
    .clk(clk),
    .reset(reset),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .is_jump(is_jump),
    .jump_addr(jump_addr),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .out_pc(out_pc),
    .instruction(instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_rdata = mem(imem_addr);

  // Model: next address to fetch, whether an instruction is parked
  // waiting for decode, and whether the in-flight request is stale.
  logic [31:0] m_pc, m_park, m_dest, m_ifpc, m_ifin;
  logic        m_parked, m_stale;

  always @(posedge clk or negedge reset) begin : model
    logic [31:0] pc, park, dest, ifpc, ifin;
    logic parked, stale, acc, jmp, tgt_ok, got;
    logic [31:0] tgt;
    if (!reset) begin
      m_pc <= 32'h0000_1000;
      m_park <= '0;
      m_dest <= '0;
      m_ifpc <= '0;
      m_ifin <= '0;
      m_parked <= 1'b0;
      m_stale <= 1'b0;
    end else begin
      pc = m_pc; park = m_park; dest = m_dest;
      ifpc = m_ifpc; ifin = m_ifin;
      parked = m_parked; stale = m_stale;
      acc = pc_write && if_id_write;
      jmp = branch_taken || (is_jump && if_id_write);
      tgt = branch_taken ? branch_addr : jump_addr;
      got = imem_ready && !parked;
      tgt_ok = 1'b0;
      if (jmp || (if_id_write && !got && !parked)) begin
        ifpc = m_pc;
        ifin = 32'h0;
      end
      if (parked) begin
        if (jmp) begin
          pc = tgt; parked = 1'b0;
        end else if (acc) begin
          ifpc = m_pc; ifin = m_park;
          pc = m_pc + 32'd4; parked = 1'b0;
        end
      end else if (stale) begin
        if (jmp) dest = tgt;
        if (got) begin
          pc = dest; stale = 1'b0;
        end
      end else if (got) begin
        if (jmp) pc = tgt;
        else if (acc) begin
          ifpc = m_pc; ifin = mem(m_pc);
          pc = m_pc + 32'd4;
        end else begin
          parked = 1'b1; park = mem(m_pc);
        end
      end else if (jmp) begin
        stale = 1'b1; dest = tgt;
      end
      if (tgt_ok) pc = pc;
      m_pc <= pc; m_park <= park; m_dest <= dest;
      m_ifpc <= ifpc; m_ifin <= ifin;
      m_parked <= parked; m_stale <= stale;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("model_req", {31'b0, imem_req}, {31'b0, !m_parked});
      if (!m_parked) chk("model_addr", imem_addr, m_pc);
      chk("model_out_pc", out_pc, m_ifpc);
      chk("model_instr", instruction, m_ifin);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input logic [31:0] p, input logic [31:0] i);
    chk("lit_out_pc", out_pc, p);
    chk("lit_instr", instruction, i);
  endtask

  initial begin
    reset = 1'b0;
    pc_write = 1'b1;
    if_id_write = 1'b1;
    is_jump = 1'b0;
    jump_addr = '0;
    branch_taken = 1'b0;
    branch_addr = '0;
    imem_ready = 1'b1;
    step(); step();
    ifid(32'h0, 32'h0);
    chk("reset_req", {31'b0, imem_req}, 32'h0);
    reset = 1'b1;
    #1;
    chk("first_addr", imem_addr, 32'h1000);
    // streaming, then a two-cycle stall at 1008
    step(); ifid(32'h1000, 32'hA5A5_1000);
    chk("addr_1004", imem_addr, 32'h1004);
    step(); ifid(32'h1004, 32'hA5A5_1004);
    pc_write = 1'b0; if_id_write = 1'b0;
    step(); ifid(32'h1004, 32'hA5A5_1004);
    chk("stall_req", {31'b0, imem_req}, 32'h0);
    step(); ifid(32'h1004, 32'hA5A5_1004);
    pc_write = 1'b1; if_id_write = 1'b1;
    step(); ifid(32'h1008, 32'hA5A5_1008);
    chk("addr_100c", imem_addr, 32'h100C);
    step(); ifid(32'h100C, 32'hA5A5_100C);
    // branch while memory is slow at 1010
    imem_ready = 1'b0;
    step(); ifid(32'h1010, 32'h0);
    branch_taken = 1'b1; branch_addr = 32'h3000;
    step(); ifid(32'h1010, 32'h0);
    chk("drop_addr", imem_addr, 32'h1010);
    branch_taken = 1'b0;
    step(); chk("drop_addr2", imem_addr, 32'h1010);
    imem_ready = 1'b1;
    step(); chk("br_addr", imem_addr, 32'h3000);
    chk("br_nop", instruction, 32'h0);
    step(); ifid(32'h3000, 32'hA5A5_3000);
    // jump from decode
    is_jump = 1'b1; jump_addr = 32'h2000;
    step(); ifid(32'h3004, 32'h0);
    chk("jmp_addr", imem_addr, 32'h2000);
    is_jump = 1'b0;
    step(); ifid(32'h2000, 32'hA5A5_2000);
    // jump ignored while decode stalls
    is_jump = 1'b1; if_id_write = 1'b0;
    step(); ifid(32'h2000, 32'hA5A5_2000);
    is_jump = 1'b0; if_id_write = 1'b1;
    step(); ifid(32'h2004, 32'hA5A5_2004);
    chk("addr_2008", imem_addr, 32'h2008);
    // branch beats jump
    branch_taken = 1'b1; branch_addr = 32'h3000; is_jump = 1'b1;
    step(); ifid(32'h2008, 32'h0);
    chk("prio_addr", imem_addr, 32'h3000);
    branch_taken = 1'b0; is_jump = 1'b0;
    step(); ifid(32'h3000, 32'hA5A5_3000);
    // branch flushes despite if_id_write=0
    branch_taken = 1'b1; branch_addr = 32'h3100;
    pc_write = 1'b0; if_id_write = 1'b0;
    step(); ifid(32'h3004, 32'h0);
    chk("flush_addr", imem_addr, 32'h3100);
    branch_taken = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
    // pc wrap
    is_jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
    step(); chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    is_jump = 1'b0;
    step(); ifid(32'hFFFF_FFFC, 32'h5A5A_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    // reset in the middle of a wait
    imem_ready = 1'b0;
    step(); chk("wait_addr", imem_addr, 32'h0);
    reset = 1'b0;
    #1;
    ifid(32'h0, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    step();
    reset = 1'b1; imem_ready = 1'b1;
    #1;
    chk("rst_addr", imem_addr, 32'h1000);
    chk("rst_req1", {31'b0, imem_req}, 32'h1);
    step(); ifid(32'h1000, 32'hA5A5_1000);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
